// File: rtl/mc_ctrl_pkg.sv
// rtl/mc_ctrl_pkg.sv - state codes and datapath select encodings for the multicycle sequencer
package mc_ctrl_pkg;

  // State codes; 10-15 are unused and recover to FETCH.
  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXECR  = 4'd6;
  localparam logic [3:0] S_EXECI  = 4'd7;
  localparam logic [3:0] S_ALUWB  = 4'd8;
  localparam logic [3:0] S_BRANCH = 4'd9;

  // alu_src_a encodings
  localparam logic [1:0] SRCA_REG  = 2'b00;
  localparam logic [1:0] SRCA_PC   = 2'b01;
  localparam logic [1:0] SRCA_ALUR = 2'b10;

  // alu_src_b encodings
  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // result_src encodings
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  // instr[27:26] op encodings
  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;
  localparam logic [1:0] OP_ILL = 2'b11;

endpackage

// File: rtl/mc_main_fsm.sv
// rtl/mc_main_fsm.sv - multicycle main control FSM for the 32-bit ARM core
//
// Ports:
//   clk, reset (async, active-low)
//   op, funct       : instruction fields from the decoder (sampled in DECODE/MEMADR)
//   mem_ready       : memory completes access this cycle
//   ir_write, next_pc, branch, reg_write, mem_write : enables/strobes
//   adr_src, alu_src_a, alu_src_b, result_src, alu_op : datapath selects
//   illegal         : one-cycle pulse when op=11 is decoded
//   state_o         : current state for debug
module mc_main_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         op,
  input  logic [5:0]         funct,
  input  logic               mem_ready,
  output logic               ir_write,
  output logic               next_pc,
  output logic               branch,
  output logic               reg_write,
  output logic               mem_write,
  output logic               adr_src,
  output logic [1:0]         alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         result_src,
  output logic               alu_op,
  output logic               illegal,
  output logic [STATE_W-1:0] state_o
);

  localparam logic [STATE_W-1:0] ST_FETCH  = STATE_W'(S_FETCH);
  localparam logic [STATE_W-1:0] ST_DECODE = STATE_W'(S_DECODE);
  localparam logic [STATE_W-1:0] ST_MEMADR = STATE_W'(S_MEMADR);
  localparam logic [STATE_W-1:0] ST_MEMRD  = STATE_W'(S_MEMRD);
  localparam logic [STATE_W-1:0] ST_MEMWB  = STATE_W'(S_MEMWB);
  localparam logic [STATE_W-1:0] ST_MEMWR  = STATE_W'(S_MEMWR);
  localparam logic [STATE_W-1:0] ST_EXECR  = STATE_W'(S_EXECR);
  localparam logic [STATE_W-1:0] ST_EXECI  = STATE_W'(S_EXECI);
  localparam logic [STATE_W-1:0] ST_ALUWB  = STATE_W'(S_ALUWB);
  localparam logic [STATE_W-1:0] ST_BRANCH = STATE_W'(S_BRANCH);

  logic [STATE_W-1:0] state_q;
  logic [STATE_W-1:0] state_d;

  // Enables before the reset gate is applied.
  logic ir_write_raw;
  logic next_pc_raw;
  logic branch_raw;
  logic reg_write_raw;
  logic mem_write_raw;
  logic illegal_raw;

  // funct[4:1] carry ALU function bits consumed by the ALU decoder, not here.
  logic unused_funct;
  assign unused_funct = ^funct[4:1];

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = ST_FETCH;
    case (state_q)
      ST_FETCH:  state_d = mem_ready ? ST_DECODE : ST_FETCH;
      ST_DECODE: begin
        case (op)
          OP_MEM:  state_d = ST_MEMADR;
          OP_DP:   state_d = funct[5] ? ST_EXECI : ST_EXECR;
          OP_BR:   state_d = ST_BRANCH;
          default: state_d = ST_FETCH;
        endcase
      end
      ST_MEMADR: state_d = funct[0] ? ST_MEMRD : ST_MEMWR;
      ST_MEMRD:  state_d = mem_ready ? ST_MEMWB : ST_MEMRD;
      ST_MEMWR:  state_d = mem_ready ? ST_FETCH : ST_MEMWR;
      ST_EXECR:  state_d = ST_ALUWB;
      ST_EXECI:  state_d = ST_ALUWB;
      default:   state_d = ST_FETCH;
    endcase
  end

  // Output decode: selects follow state only; memory strobes wait on mem_ready.
  always_comb begin
    ir_write_raw  = 1'b0;
    next_pc_raw   = 1'b0;
    branch_raw    = 1'b0;
    reg_write_raw = 1'b0;
    mem_write_raw = 1'b0;
    illegal_raw   = 1'b0;
    adr_src       = 1'b0;
    alu_src_a     = 2'b00;
    alu_src_b     = 2'b00;
    result_src    = 2'b00;
    alu_op        = 1'b0;
    case (state_q)
      ST_FETCH: begin
        alu_src_a    = SRCA_PC;
        alu_src_b    = SRCB_FOUR;
        result_src   = RES_ALU;
        ir_write_raw = mem_ready;
        next_pc_raw  = mem_ready;
      end
      ST_DECODE: begin
        // PC already advanced by 4, so this sum gives R15 = PC+8.
        alu_src_a   = SRCA_PC;
        alu_src_b   = SRCB_FOUR;
        result_src  = RES_ALU;
        illegal_raw = (op == OP_ILL);
      end
      ST_MEMADR: begin
        alu_src_a = SRCA_REG;
        alu_src_b = SRCB_IMM;
      end
      ST_MEMRD: begin
        adr_src    = 1'b1;
        result_src = RES_ALUOUT;
      end
      ST_MEMWB: begin
        result_src    = RES_DATA;
        reg_write_raw = 1'b1;
      end
      ST_MEMWR: begin
        adr_src       = 1'b1;
        result_src    = RES_ALUOUT;
        mem_write_raw = mem_ready;
      end
      ST_EXECR: begin
        alu_src_a = SRCA_REG;
        alu_src_b = SRCB_REG;
        alu_op    = 1'b1;
      end
      ST_EXECI: begin
        alu_src_a = SRCA_REG;
        alu_src_b = SRCB_IMM;
        alu_op    = 1'b1;
      end
      ST_ALUWB: begin
        result_src    = RES_ALUOUT;
        reg_write_raw = 1'b1;
      end
      ST_BRANCH: begin
        alu_src_a  = SRCA_ALUR;
        alu_src_b  = SRCB_IMM;
        result_src = RES_ALU;
        branch_raw = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Gate enables with reset so nothing writes while reset is held, even
  // in the same cycle the asynchronous reset lands.
  assign ir_write  = ir_write_raw  & reset;
  assign next_pc   = next_pc_raw   & reset;
  assign branch    = branch_raw    & reset;
  assign reg_write = reg_write_raw & reset;
  assign mem_write = mem_write_raw & reset;
  assign illegal   = illegal_raw   & reset;
  assign state_o   = state_q;

endmodule

// File: tb/tb_mc_main_fsm.sv
// tb/tb_mc_main_fsm.sv - directed self-checking bench for mc_main_fsm
module tb_mc_main_fsm;

  logic       clk;
  logic       reset;
  logic [1:0] op;
  logic [5:0] funct;
  logic       mem_ready;
  logic       ir_write, next_pc, branch, reg_write, mem_write;
  logic       adr_src, alu_op, illegal;
  logic [1:0] alu_src_a, alu_src_b, result_src;
  logic [3:0] state_o;

  int n_checks;
  int n_fail;

  mc_main_fsm #(.STATE_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct      (funct),
    .mem_ready  (mem_ready),
    .ir_write   (ir_write),
    .next_pc    (next_pc),
    .branch     (branch),
    .reg_write  (reg_write),
    .mem_write  (mem_write),
    .adr_src    (adr_src),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .result_src (result_src),
    .alu_op     (alu_op),
    .illegal    (illegal),
    .state_o    (state_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reset held 3 cycles, then a data-proc register instruction: 0,1,6,8,0.
  task automatic test_reset();
    logic [3:0] exp_st [5];
    exp_st = '{4'd0, 4'd1, 4'd6, 4'd8, 4'd0};
    op = 2'b00; funct = 6'b000000; mem_ready = 1'b1;
    #2 reset = 1'b0;
    repeat (3) begin
      @(negedge clk); #1;
      n_checks++;
      if (state_o !== 4'd0) begin
        n_fail++; $display("FAIL reset_state: got %0d want 0", state_o);
      end
      n_checks++;
      if ({ir_write, next_pc, branch, reg_write, mem_write, illegal} !== 6'b0) begin
        n_fail++; $display("FAIL reset_enables: got %b want 000000",
          {ir_write, next_pc, branch, reg_write, mem_write, illegal});
      end
      n_checks++;
      if ({adr_src, alu_src_a, alu_src_b, result_src, alu_op} !== 8'b0_01_10_10_0) begin
        n_fail++; $display("FAIL reset_selects: got %b want 00110100",
          {adr_src, alu_src_a, alu_src_b, result_src, alu_op});
      end
    end
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      n_checks++;
      if (state_o !== exp_st[i]) begin
        n_fail++; $display("FAIL dp_seq[%0d]: got %0d want %0d", i, state_o, exp_st[i]);
      end
      n_checks++;
      if (reg_write !== (exp_st[i] == 4'd8)) begin
        n_fail++; $display("FAIL dp_reg_write[%0d]: got %b want %b", i, reg_write, exp_st[i] == 4'd8);
      end
      if (i == 2) begin
        n_checks++;
        if ({alu_src_a, alu_src_b, alu_op} !== 5'b00_00_1) begin
          n_fail++; $display("FAIL execr_sel: got %b want 00001", {alu_src_a, alu_src_b, alu_op});
        end
      end
    end
  endtask

  // Load: 0,1,2,3,4,0.
  task automatic test_load();
    logic [3:0] exp_st [6];
    exp_st = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
    op = 2'b01; funct = 6'b000001; mem_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      n_checks++;
      if (state_o !== exp_st[i]) begin
        n_fail++; $display("FAIL load_seq[%0d]: got %0d want %0d", i, state_o, exp_st[i]);
      end
      n_checks++;
      if (reg_write !== (exp_st[i] == 4'd4)) begin
        n_fail++; $display("FAIL load_reg_write[%0d]: got %b want %b", i, reg_write, exp_st[i] == 4'd4);
      end
      n_checks++;
      if (adr_src !== (exp_st[i] == 4'd3)) begin
        n_fail++; $display("FAIL load_adr_src[%0d]: got %b want %b", i, adr_src, exp_st[i] == 4'd3);
      end
      if (i == 2) begin
        n_checks++;
        if ({alu_src_a, alu_src_b, alu_op} !== 5'b00_01_0) begin
          n_fail++; $display("FAIL memadr_sel: got %b want 00010", {alu_src_a, alu_src_b, alu_op});
        end
      end
      if (i == 4) begin
        n_checks++;
        if (result_src !== 2'b01) begin
          n_fail++; $display("FAIL memwb_result_src: got %b want 01", result_src);
        end
      end
    end
  endtask

  // Store with two wait cycles in MEMWR: 0,1,2,5,5,5,0; one mem_write pulse.
  task automatic test_store_wait();
    logic [3:0] exp_st [7];
    logic       mr     [7];
    logic       exp_mw [7];
    int         pulses;
    exp_st = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd5, 4'd5, 4'd0};
    mr     = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    exp_mw = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    pulses = 0;
    op = 2'b01; funct = 6'b000000;
    for (int i = 0; i < 7; i++) begin
      if (i > 0) @(negedge clk);
      mem_ready = mr[i];
      #1;
      if (mem_write === 1'b1) pulses++;
      n_checks++;
      if (state_o !== exp_st[i]) begin
        n_fail++; $display("FAIL store_seq[%0d]: got %0d want %0d", i, state_o, exp_st[i]);
      end
      n_checks++;
      if (mem_write !== exp_mw[i]) begin
        n_fail++; $display("FAIL store_mem_write[%0d]: got %b want %b", i, mem_write, exp_mw[i]);
      end
      if (exp_st[i] == 4'd5) begin
        n_checks++;
        if (adr_src !== 1'b1) begin
          n_fail++; $display("FAIL memwr_adr_src[%0d]: got %b want 1", i, adr_src);
        end
      end
    end
    n_checks++;
    if (pulses != 1) begin
      n_fail++; $display("FAIL store_pulse_count: got %0d want 1", pulses);
    end
    mem_ready = 1'b1;
  endtask

  // Fetch waits 4 cycles, then an immediate data-proc: 0x5,1,7,8,0.
  task automatic test_fetch_wait();
    logic [3:0] exp_st [9];
    logic       mr     [9];
    exp_st = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd7, 4'd8, 4'd0};
    mr     = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    op = 2'b00; funct = 6'b100000;
    for (int i = 0; i < 9; i++) begin
      if (i > 0) @(negedge clk);
      mem_ready = mr[i];
      #1;
      n_checks++;
      if (state_o !== exp_st[i]) begin
        n_fail++; $display("FAIL fwait_seq[%0d]: got %0d want %0d", i, state_o, exp_st[i]);
      end
      n_checks++;
      if ({ir_write, next_pc} !== {2{(i == 4) || (i == 8)}}) begin
        n_fail++; $display("FAIL fwait_irw_npc[%0d]: got %b%b want %b", i, ir_write, next_pc,
          {2{(i == 4) || (i == 8)}});
      end
      if (i == 6) begin
        n_checks++;
        if ({alu_src_a, alu_src_b, alu_op} !== 5'b00_01_1) begin
          n_fail++; $display("FAIL execi_sel: got %b want 00011", {alu_src_a, alu_src_b, alu_op});
        end
      end
    end
  endtask

  // Branch 0,1,9,0 then illegal 0,1,0.
  task automatic test_branch_illegal();
    logic [3:0] exp_st [7];
    logic [1:0] ops    [7];
    exp_st = '{4'd0, 4'd1, 4'd9, 4'd0, 4'd1, 4'd0, 4'd1};
    ops    = '{2'b10, 2'b10, 2'b10, 2'b11, 2'b11, 2'b11, 2'b00};
    funct = 6'b000000; mem_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      if (i > 0) @(negedge clk);
      op = ops[i];
      #1;
      n_checks++;
      if (state_o !== exp_st[i]) begin
        n_fail++; $display("FAIL br_ill_seq[%0d]: got %0d want %0d", i, state_o, exp_st[i]);
      end
      n_checks++;
      if (branch !== (i == 2)) begin
        n_fail++; $display("FAIL branch_en[%0d]: got %b want %b", i, branch, i == 2);
      end
      n_checks++;
      if (illegal !== (i == 4)) begin
        n_fail++; $display("FAIL illegal_pulse[%0d]: got %b want %b", i, illegal, i == 4);
      end
      if (i == 2) begin
        n_checks++;
        if ({alu_src_a, alu_src_b, result_src} !== 6'b10_01_10) begin
          n_fail++; $display("FAIL branch_sel: got %b want 100110", {alu_src_a, alu_src_b, result_src});
        end
      end
    end
    // The last cycle is DECODE with op=00: finish it as data-proc 6,8,0.
    op = 2'b00;
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if (state_o !== 4'd0) begin
      n_fail++; $display("FAIL br_ill_tail: got %0d want 0", state_o);
    end
  endtask

  // Reset asserted mid-MEMWB: state and reg_write drop before the next edge.
  task automatic test_reset_mid();
    op = 2'b01; funct = 6'b000001; mem_ready = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    n_checks++;
    if ({state_o, reg_write} !== {4'd4, 1'b1}) begin
      n_fail++; $display("FAIL pre_reset_memwb: got st=%0d rw=%b want st=4 rw=1", state_o, reg_write);
    end
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if (state_o !== 4'd0) begin
      n_fail++; $display("FAIL async_reset_state: got %0d want 0", state_o);
    end
    n_checks++;
    if (reg_write !== 1'b0) begin
      n_fail++; $display("FAIL async_reset_reg_write: got %b want 0", reg_write);
    end
    @(negedge clk); #1;
    n_checks++;
    if ({state_o, ir_write, next_pc} !== {4'd0, 2'b00}) begin
      n_fail++; $display("FAIL reset_hold: got st=%0d irw=%b npc=%b want 0,0,0", state_o, ir_write, next_pc);
    end
    reset = 1'b1;
    @(negedge clk); #1;
    n_checks++;
    if (state_o !== 4'd1) begin
      n_fail++; $display("FAIL post_reset_fetch: got %0d want 1", state_o);
    end
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    reset     = 1'b1;
    op        = 2'b00;
    funct     = 6'b000000;
    mem_ready = 1'b0;
    test_reset();
    test_load();
    test_store_wait();
    test_fetch_wait();
    test_branch_illegal();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
